// File: rtl/mem_load_arbiter.sv
// Sequential memory loader with a round-robin shared host port.
// Stream beats fill words 0..M-1 in order; the host gets random read/write access to the same port.
module mem_load_arbiter #(
    parameter int M  = 320,
    parameter int N  = 8,
    parameter int AW = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stream_start,
    input  logic          stream_valid,
    input  logic [N-1:0]  stream_data,
    output logic          stream_ready,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [N-1:0]  host_wdata,
    output logic          host_gnt,
    output logic [N-1:0]  host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_we,
    input  logic [N-1:0]  mem_rdata,
    output logic [AW:0]   load_count,
    output logic          load_done,
    output logic [1:0]    fsm_state
);

    // fsm_state encoding: 0 = IDLE, 1 = LOAD, 2 = DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   M_LIMIT   = (AW+1)'(M);
    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic          last_host;   // 1 when the host won the most recent grant
    logic          stream_fire;
    logic          host_in_range;
    logic          rd_pend;
    logic          rd_oor;

    // Handshake: a stream beat transfers on a cycle where stream_valid and
    // stream_ready are both 1; ready is only offered in LOAD and is withdrawn
    // on restart cycles and on cycles where the host owns the memory port.
    always_comb begin
        state_nxt    = state;
        host_gnt     = 1'b0;
        stream_ready = 1'b0;
        if (!reset) begin
            if (state == LOAD) begin
                if (host_req && stream_valid)
                    host_gnt = !last_host;
                else
                    host_gnt = host_req;
                stream_ready = !stream_start && !host_gnt;
            end else begin
                host_gnt = host_req;
            end
        end
        if (stream_start)
            state_nxt = LOAD;
        else if (stream_fire && ptr == LAST_ADDR)
            state_nxt = DONE;
    end

    assign stream_fire   = stream_valid && stream_ready;
    assign host_in_range = {1'b0, host_addr} < M_LIMIT;
    assign fsm_state     = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            load_count  <= '0;
            load_done   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
            rd_pend     <= 1'b0;
            rd_oor      <= 1'b0;
            last_host   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_we      <= 1'b0;
            host_rvalid <= rd_pend;
            rd_pend     <= host_gnt && !host_we;
            rd_oor      <= !host_in_range;
            // Read data comes back one cycle after the address was presented.
            if (rd_pend)
                host_rdata <= rd_oor ? '0 : mem_rdata;

            if (stream_start) begin
                ptr        <= '0;
                load_count <= '0;
                load_done  <= 1'b0;
            end else if (stream_fire) begin
                mem_addr   <= ptr;
                mem_wdata  <= stream_data;
                mem_we     <= 1'b1;
                load_count <= load_count + 1'b1;
                last_host  <= 1'b0;
                if (ptr == LAST_ADDR)
                    load_done <= 1'b1;
                else
                    ptr <= ptr + 1'b1;
            end

            // Never coincides with stream_fire, so the memory port has one owner.
            if (host_gnt) begin
                last_host <= 1'b1;
                if (host_we) begin
                    if (host_in_range) begin
                        mem_addr  <= host_addr;
                        mem_wdata <= host_wdata;
                        mem_we    <= 1'b1;
                    end
                end else begin
                    mem_addr <= host_addr;
                end
            end
        end
    end

endmodule
